scan_controller: RTL and testbench

SCAN_CONTROLLER -- requirements
Module: scan_controller

---
 rtl/scan_controller.sv | 144 ++++++++++++++
 tb/tb_scan_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/scan_controller.sv
// Byte-wide host bridge to a serial scan chain: EXCHANGE shifts host bytes in while
// capturing the old contents; DUMP recirculates the chain so it reads back unchanged.
module scan_controller #(
  parameter int CHAIN_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       busy,
  output logic       done
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    PUSH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            mode_r;
  logic [2:0]      bit_cnt_r;
  logic [BW-1:0]   byte_cnt_r;
  logic [7:0]      shreg_r;
  logic [7:0]      capture_r;

  assign out_data = capture_r;

  // Next-state and state-decoded chain/handshake outputs
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    scan_enable = 1'b0;
    scan_in     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt_s = mode ? SHIFT : FETCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      SHIFT: begin
        scan_enable = 1'b1;
        scan_in     = mode_r ? scan_out : shreg_r[bit_cnt_r];
        if (bit_cnt_r == 3'd7) begin
          state_nxt_s = PUSH;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      PUSH: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (byte_cnt_r == LAST_BYTE) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = mode_r ? SHIFT : FETCH;
          end
        end else begin
          state_nxt_s = PUSH;
        end
      end
      DONE: begin
        done        = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        busy        = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and data registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      mode_r     <= 1'b0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      shreg_r    <= 8'h00;
      capture_r  <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            mode_r     <= mode;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= '0;
          end
        end
        FETCH: begin
          if (in_valid) begin
            shreg_r <= in_data;
          end
        end
        SHIFT: begin
          // bit_cnt wraps to 0 after the 8th shift, ready for the next byte
          capture_r[bit_cnt_r] <= scan_out;
          bit_cnt_r            <= bit_cnt_r + 3'd1;
        end
        PUSH: begin
          if (out_ready) begin
            byte_cnt_r <= byte_cnt_r + {{(BW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= state_nxt_s;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_controller.sv
// Self-checking bench: behavioural 256-bit chain, table of chain operations with a
// byte scoreboard, plus hand sequences for FETCH stall and mid-shift reset.
module tb_scan_controller;

  localparam int N  = 256;
  localparam int NB = N / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, scan_enable, scan_in, scan_out, busy, done;
  logic [7:0] out_data;

  logic         load_chain = 1'b0;
  logic [N-1:0] init_pat;
  logic [N-1:0] chain;

  scan_controller #(.CHAIN_LEN(N)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Chain model: head receives scan_in, tail (bit 0) drives scan_out
  assign scan_out = chain[0];
  always @(posedge clk) begin
    if (load_chain) chain <= init_pat;
    else if (scan_enable) chain <= {scan_in, chain[N-1:1]};
  end

  int         nvec = 0;
  int         nmis = 0;
  logic [7:0] exp_img [NB];
  logic [7:0] sb [$];

  typedef struct {
    logic       md;
    logic [7:0] base;
    int         stall;
    int         exp_se;
    int         exp_busy;
  } op_t;
  op_t ops [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input op_t op);
    int in_idx, out_idx, se, bz, dn, stall_left, cyc;
    logic fin;
    logic [7:0] held, expb;
    in_idx = 0; out_idx = 0; se = 0; bz = 0; dn = 0; cyc = 0;
    stall_left = op.stall; fin = 1'b0; held = 8'h00;
    for (int k = 0; k < NB; k++) sb.push_back(exp_img[k]);
    @(negedge clk);
    start = 1'b1; mode = op.md; in_valid = 1'b1; out_ready = 1'b1; in_data = op.base;
    @(negedge clk);
    start = 1'b0; mode = 1'b0;
    while (!fin && cyc < 3000) begin
      cyc++;
      in_data   = op.base + 8'(in_idx);
      start     = (cyc == 40);
      mode      = ~op.md;
      out_ready = 1'b1;
      if (out_valid && out_idx == 5 && stall_left > 0) begin
        out_ready = 1'b0;
        if (stall_left == op.stall) held = out_data;
        else chk("stall_data", {24'h0, out_data}, {24'h0, held});
        chk("stall_scan_enable", {31'h0, scan_enable}, 32'h0);
        stall_left--;
      end
      if (scan_enable) se++;
      if (busy && !done) bz++;
      if (done) begin
        dn++;
        fin = 1'b1;
        chk("done_busy", {31'h0, busy}, 32'h1);
      end
      if (in_valid && in_ready) in_idx++;
      if (out_valid && out_ready) begin
        if (sb.size() > 0) begin
          expb = sb.pop_front();
          chk("out_byte", {24'h0, out_data}, {24'h0, expb});
        end else begin
          chk("unexpected_byte", 32'h1, 32'h0);
        end
        out_idx++;
      end
      @(negedge clk);
    end
    start = 1'b0; mode = 1'b0;
    chk("op_finished", {31'h0, fin}, 32'h1);
    chk("done_one_cycle", {31'h0, done}, 32'h0);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("shift_count", 32'(se), 32'(op.exp_se));
    chk("busy_cycles", 32'(bz), 32'(op.exp_busy));
    chk("done_count", 32'(dn), 32'h1);
    chk("bytes_in", 32'(in_idx), op.md ? 32'h0 : 32'(NB));
    chk("bytes_out", 32'(out_idx), 32'(NB));
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    sb.delete();
    if (!op.md) for (int k = 0; k < NB; k++) exp_img[k] = op.base + 8'(k);
  endtask

  initial begin
    int se;
    int cyc;
    logic [N-1:0] snap;
    ops[0] = '{1'b0, 8'h00, 0,  256, 320};
    ops[1] = '{1'b1, 8'h00, 0,  256, 288};
    ops[2] = '{1'b1, 8'h00, 0,  256, 288};
    ops[3] = '{1'b0, 8'hA0, 20, 256, 340};
    ops[4] = '{1'b1, 8'h00, 0,  256, 288};

    for (int j = 0; j < N / 32; j++) init_pat[32*j +: 32] = $urandom;
    for (int k = 0; k < NB; k++) exp_img[k] = init_pat[8*k +: 8];

    rst = 1'b0; load_chain = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_scan_enable", {31'h0, scan_enable}, 32'h0);
    chk("rst_scan_in", {31'h0, scan_in}, 32'h0);
    chk("rst_out_data", {24'h0, out_data}, 32'h0);
    load_chain = 1'b0; rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_op(ops[i]);

    // EXCHANGE started with no host data: must sit in FETCH without shifting
    start = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      chk("fetch_hold_ready", {31'h0, in_ready}, 32'h1);
      chk("fetch_hold_se", {31'h0, scan_enable}, 32'h0);
      @(negedge clk);
    end

    // Feed bytes, then reset in the middle of the fourth byte's shift
    in_valid = 1'b1; se = 0; cyc = 0;
    in_data = 8'h50;
    while (se < 27 && cyc < 500) begin
      cyc++;
      if (scan_enable) se++;
      if (se == 27) rst = 1'b0;
      else begin
        if (in_valid && in_ready) in_data = in_data + 8'h01;
        @(negedge clk);
      end
    end
    chk("reach_mid_shift", 32'(se), 32'd27);
    @(negedge clk);
    in_valid = 1'b0;
    snap = chain;
    chk("abort_scan_enable", {31'h0, scan_enable}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_in_ready", {31'h0, in_ready}, 32'h0);
    chk("abort_out_data", {24'h0, out_data}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    se = 0;
    for (int c = 0; c < 20; c++) begin
      if (scan_enable) se++;
      @(negedge clk);
    end
    chk("post_reset_shifts", 32'(se), 32'h0);
    chk("post_reset_chain", {31'h0, chain == snap}, 32'h1);
    chk("post_reset_idle", {31'h0, busy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
